// File: rtl/data_fanout_pkg.sv
// data_fanout_pkg
//   Shared definitions for the data_fanout block: the dispatch mode
//   enumeration, default parameter values, and the round-robin pointer
//   width/advance helper used by the top level.
package data_fanout_pkg;

    // Dispatch mode held in the internal mode register.
    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_BCAST = 1'b1
    } mode_e;

    localparam int DEF_DATA_W = 5;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_DEPTH  = 4;

    // Fixed pointer width covering the largest legal channel count (8),
    // so the pointer and its debug port never collapse to zero bits.
    localparam int PTR_W = 3;

    // Next round-robin channel: wraps from num_ch-1 back to 0.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr,
                                                  input int               num_ch);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(num_ch - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a registered "can accept" flag.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     push, push_data   write request (only honoured while in_rdy is high)
//     pop               remove head word (ignored when empty)
//     head_data         current head word (valid while empty is low)
//     empty             no words stored
//     in_rdy            registered: next level below DEPTH; no write-through
//                       when full, even if a pop happens in the same cycle
//     level             current occupancy, 0..DEPTH
module sync_fifo
    import data_fanout_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head_data,
    output logic                         empty,
    output logic                         in_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              rdy_q,    rdy_d;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign do_push = push && rdy_q;
    assign do_pop  = pop && (level_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        rdy_d = (level_d < FULL_LVL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_q    <= rdy_d;
        end
    end

    // Storage needs no reset: contents are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign empty     = (level_q == '0);
    assign in_rdy    = rdy_q;
    assign level     = level_q;

endmodule

// File: rtl/data_fanout.sv
// data_fanout
//   Buffers input words in a FIFO and distributes them to NUM_CH output
//   channels, either round-robin (one channel per word, strict order) or
//   broadcast (every channel receives every word).
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     data_in, data_in_vld/_rdy     input stream
//     bcast_mode                    requested mode, sampled only when idle
//     data_out                      channel k at [k*DATA_W +: DATA_W]
//     data_out_vld/_rdy             per-channel output handshake
//     data_en                       any output valid or FIFO non-empty
//     fifo_level                    FIFO occupancy
//     dbg_ptr, dbg_mode             round-robin pointer and mode register
//
//   Handshake: every port pair uses valid/ready; a word moves on a rising
//   edge where valid and ready are both high. A source never withdraws or
//   changes a word while valid is high and ready is low.
module data_fanout
    import data_fanout_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         data_in_vld,
    output logic                         data_in_rdy,
    input  logic                         bcast_mode,
    output logic [NUM_CH*DATA_W-1:0]     data_out,
    output logic [NUM_CH-1:0]            data_out_vld,
    input  logic [NUM_CH-1:0]            data_out_rdy,
    output logic                         data_en,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [PTR_W-1:0]             dbg_ptr,
    output logic                         dbg_mode
);

    logic [NUM_CH-1:0]              vld_q, vld_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  hold_q, hold_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    mode_e                          mode_q, mode_d;

    logic [NUM_CH-1:0]              free;
    logic [NUM_CH-1:0]              sel;
    logic                           pop;
    logic                           push;
    logic                           fifo_empty;
    logic [DATA_W-1:0]              head;

    assign push = data_in_vld && data_in_rdy;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty),
        .in_rdy    (data_in_rdy),
        .level     (fifo_level)
    );

    always_comb begin
        vld_d  = vld_q;
        hold_d = hold_q;
        ptr_d  = ptr_q;
        mode_d = mode_q;
        pop    = 1'b0;
        free   = '0;
        sel    = '0;

        // A holding register is free if empty or emptying this cycle.
        for (int k = 0; k < NUM_CH; k++) begin
            free[k] = !vld_q[k] || data_out_rdy[k];
            sel[k]  = (ptr_q == PTR_W'(k));
            if (vld_q[k] && data_out_rdy[k]) begin
                vld_d[k] = 1'b0;
            end
        end

        if (!fifo_empty) begin
            if (mode_q == MODE_BCAST) begin
                // All channels must be free so the word lands everywhere at once.
                if (&free) begin
                    pop = 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        vld_d[k]  = 1'b1;
                        hold_d[k] = head;
                    end
                end
            end else if ((free & sel) != '0) begin
                // Strict order: only the pointed-to channel may take the head.
                pop   = 1'b1;
                ptr_d = next_ptr(ptr_q, NUM_CH);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel[k]) begin
                        vld_d[k]  = 1'b1;
                        hold_d[k] = head;
                    end
                end
            end
        end

        // Mode only changes while nothing is buffered or in flight.
        if (fifo_empty && (vld_q == '0)) begin
            mode_d = mode_e'(bcast_mode);
            if (mode_d != mode_q) begin
                ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            hold_q <= '0;
            ptr_q  <= '0;
            mode_q <= MODE_RR;
        end else begin
            vld_q  <= vld_d;
            hold_q <= hold_d;
            ptr_q  <= ptr_d;
            mode_q <= mode_d;
        end
    end

    assign data_out     = hold_q;
    assign data_out_vld = vld_q;
    assign data_en      = (vld_q != '0) || !fifo_empty;
    assign dbg_ptr      = ptr_q;
    assign dbg_mode     = mode_q;

endmodule

// File: doc/data_fanout.md
DATA_FANOUT -- requirements
Module: data_fanout

Interface
REQ-001 Parameter DATA_W, default 5, width of each data word.
REQ-002 Parameter NUM_CH, default 2, number of output channels (legal range 1..8).
REQ-003 Parameter DEPTH, default 4, input FIFO depth in words (power of two, at least 2).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 data_in  in  DATA_W  input word.
REQ-007 data_in_vld  in  1  data_in valid.
REQ-008 data_in_rdy  out  1  block can accept a word; transfer occurs when data_in_vld and data_in_rdy are both high.
REQ-009 bcast_mode  in  1  0 = round-robin, 1 = broadcast; see REQ-020.
REQ-010 data_out  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 data_out_vld  out  NUM_CH  per-channel valid.
REQ-012 data_out_rdy  in  NUM_CH  per-channel ready; channel k transfers when data_out_vld[k] and data_out_rdy[k] are both high.
REQ-013 data_en  out  1  high when any data_out_vld bit is high or the FIFO is non-empty.
REQ-014 fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-015 data_in_rdy SHALL be a register equal to (next fifo_level < DEPTH); no write-through bypass when the FIFO is full, even if a pop occurs in the same cycle.
REQ-016 Simultaneous push and pop SHALL leave fifo_level unchanged; level SHALL never exceed DEPTH nor underflow.
REQ-017 Each channel SHALL have one output holding register; a holding register is free when data_out_vld[k]=0 or its transfer completes in that cycle.
REQ-018 Round-robin mode: head word SHALL dispatch to channel ptr only when that channel is free; ptr then advances ptr+1, wrapping NUM_CH-1 to 0; a stalled channel blocks dispatch (strict order, no skipping).
REQ-019 Broadcast mode: head word SHALL dispatch to all channels in one cycle only when every channel is free; each channel then drains independently.
REQ-020 Internal mode register SHALL load bcast_mode only while the FIFO is empty and all data_out_vld are 0; any mode change SHALL reset ptr to 0; bcast_mode is ignored at other times.
REQ-021 Minimum latency: word accepted on the edge ending cycle N SHALL appear with data_out_vld high in cycle N+2; sustained throughput SHALL be one word per cycle in round-robin mode when all channels are ready.
REQ-022 Word order per channel SHALL match input order; no word SHALL be dropped or duplicated (except the intended duplication in broadcast).
REQ-023 data_out[k] SHALL hold stable while data_out_vld[k]=1 and data_out_rdy[k]=0.
REQ-024 NUM_CH=1: both modes SHALL behave identically to a FIFO followed by one register stage.

Reset
REQ-025 While rst is high: data_out_vld=0, data_out=0, data_in_rdy=0, data_en=0, fifo_level=0, ptr=0, mode register=0.
REQ-026 data_in_rdy SHALL rise on the first clock edge after rst deasserts.
REQ-027 Reset asserted mid-transfer SHALL discard all FIFO and holding-register contents immediately, without waiting for a clock edge.

Structure
REQ-028 Package data_fanout_pkg SHALL hold the mode enumeration (MODE_RR, MODE_BCAST) and the default parameter constants.
REQ-029 The FIFO SHALL be a separate sub-module, sync_fifo (parameters DATA_W and DEPTH; same clk and rst), instantiated once.

Verification
REQ-030 Reset release, with data_in_vld held low -> data_in_rdy=1 one cycle later; all outputs are 0; fifo_level=0.
REQ-031 Round-robin, NUM_CH=2, all ready, words 1,2,3,4 -> ch0 receives 1,3 and ch1 receives 2,4; first data_out_vld appears 2 cycles after the first accept.
REQ-032 Fill with ch0 ready held low, DEPTH=4 -> after 4 FIFO words plus the in-flight word, data_in_rdy=0 and fifo_level=4; releasing ch0 drains in order with no loss.
REQ-033 Broadcast, word 0x15, ch1 ready low for 3 cycles -> ch0 transfers immediately; ch1 holds 0x15 stable; next word is not dispatched until ch1 transfers.
REQ-034 Toggle bcast_mode while words are pending -> no effect until the block is empty; then the new mode applies and ptr=0.
REQ-035 Assert rst with the FIFO at level 3 and data_out_vld=2'b11 -> all outputs are 0 immediately (asynchronously); after release, no stale word reappears.
